execute_stage: RTL

- Pipeline stage directly downstream of decoder_stage; consumes its decoded fields and control bits and produces registered ALU results for the memory/writeback stages.
- Executes single-cycle ALU, shift, compare, load/store address, branch and JAL operations with 1-cycle latency.
- Executes MULT/MULTU/DIV/DIVU iteratively into internal HI/LO registers (32 cycles), asserting a stall to the upstream stages while busy.

---
 rtl/execute_stage.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// execute_stage
//   Execute stage that sits behind decoder_stage. Single-cycle ALU, shift,
//   compare, load/store address, branch and JAL operations return a
//   registered result one clock after they are accepted. MULT/MULTU/DIV/DIVU
//   run iteratively (shift-add / restoring, one bit per clock, 32 clocks)
//   into internal HI/LO registers while es_o_stall holds the upstream stages.
//
// Ports
//   es_clk, es_rst        clock; synchronous active-low reset
//   es_i_ce               input valid from decoder_stage
//   es_i_opcode/funct     instruction opcode and R-type funct
//   es_i_data_rs/rt       register operands
//   es_i_imm              immediate, bits [10:6] double as shamt
//   es_i_rd_addr          destination register index
//   es_i_pc               PC of this instruction
//   es_i_alu_src ...      decoder control bits (alu_src, memwrite, memtoreg,
//                         reg_wr, jal) and the JAL target field
//   es_o_ce               output valid
//   es_o_alu_result       result / memory address
//   es_o_data_store       rt passthrough for stores
//   es_o_rd_addr ...      registered destination and control bits
//   es_o_branch_taken     BEQ/BNE condition true
//   es_o_branch_target    pc+4 + sext(imm)<<2
//   es_o_jal_target       {pc+4[31:28], jal_addr, 2'b00}
//   es_o_stall            multi-cycle unit busy
module execute_stage #(
   parameter int DWIDTH    = 32,
   parameter int AWIDTH    = 5,
   parameter int IMM_WIDTH = 16,
   parameter int PC_WIDTH  = 32,
   localparam int OPCODE_WIDTH = 6,
   localparam int FUNCT_WIDTH  = 6,
   localparam int JUMP_WIDTH   = 26
) (
   input  logic                    es_clk,
   input  logic                    es_rst,
   input  logic                    es_i_ce,
   input  logic [OPCODE_WIDTH-1:0] es_i_opcode,
   input  logic [FUNCT_WIDTH-1:0]  es_i_funct,
   input  logic [DWIDTH-1:0]       es_i_data_rs,
   input  logic [DWIDTH-1:0]       es_i_data_rt,
   input  logic [IMM_WIDTH-1:0]    es_i_imm,
   input  logic [AWIDTH-1:0]       es_i_rd_addr,
   input  logic [PC_WIDTH-1:0]     es_i_pc,
   input  logic                    es_i_alu_src,
   input  logic                    es_i_memwrite,
   input  logic                    es_i_memtoreg,
   input  logic                    es_i_reg_wr,
   input  logic                    es_i_jal,
   input  logic [JUMP_WIDTH-1:0]   es_i_jal_addr,
   output logic                    es_o_ce,
   output logic [DWIDTH-1:0]       es_o_alu_result,
   output logic [DWIDTH-1:0]       es_o_data_store,
   output logic [AWIDTH-1:0]       es_o_rd_addr,
   output logic                    es_o_reg_wr,
   output logic                    es_o_memwrite,
   output logic                    es_o_memtoreg,
   output logic                    es_o_jal,
   output logic                    es_o_branch_taken,
   output logic [PC_WIDTH-1:0]     es_o_branch_target,
   output logic [PC_WIDTH-1:0]     es_o_jal_target,
   output logic                    es_o_stall
);
   localparam int CNT_W = $clog2(DWIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t state, state_next;

   logic [CNT_W-1:0]  cnt;
   logic [DWIDTH-1:0] hi, lo;
   // shared iteration registers: wk_a = partial product high / remainder,
   // wk_b = multiplier / dividend-quotient, wk_m = multiplicand / divisor
   logic [DWIDTH-1:0] wk_a, wk_b, wk_m;
   logic              neg_q, neg_r, div0;

   logic [DWIDTH-1:0] imm_sext, imm_zext, op_b, alu_res, mag_rs, mag_rt;
   logic [4:0]        shamt;
   logic              known, is_muldiv, md_mult, md_signed, taken;
   logic [PC_WIDTH-1:0] pc4, br_off;

   logic [DWIDTH:0]   mul_sum, div_r, div_diff;
   logic [DWIDTH-1:0] step_a, step_b, fin_hi, fin_lo, q_mag, r_mag;
   logic [2*DWIDTH-1:0] prod_mag, prod;
   logic              last_iter;

   assign es_o_stall = (state == MUL) || (state == DIV);
   assign last_iter  = (cnt == CNT_W'(DWIDTH-1));

   // ---------------- decode / single-cycle ALU ----------------
   always_comb begin
      imm_sext  = {{(DWIDTH-IMM_WIDTH){es_i_imm[IMM_WIDTH-1]}}, es_i_imm};
      imm_zext  = {{(DWIDTH-IMM_WIDTH){1'b0}}, es_i_imm};
      // logical immediates zero-extend, everything else sign-extends
      if (!es_i_alu_src)
         op_b = es_i_data_rt;
      else if (es_i_opcode == 6'h0C || es_i_opcode == 6'h0D || es_i_opcode == 6'h0E)
         op_b = imm_zext;
      else
         op_b = imm_sext;
      shamt     = es_i_imm[10:6];
      pc4       = es_i_pc + PC_WIDTH'(4);
      br_off    = {{(PC_WIDTH-IMM_WIDTH-2){es_i_imm[IMM_WIDTH-1]}}, es_i_imm, 2'b00};
      alu_res   = '0;
      known     = 1'b1;
      is_muldiv = 1'b0;
      md_mult   = 1'b0;
      md_signed = 1'b0;
      taken     = 1'b0;
      case (es_i_opcode)
         6'h00: case (es_i_funct)
            6'h20, 6'h21: alu_res = es_i_data_rs + op_b;
            6'h22, 6'h23: alu_res = es_i_data_rs - op_b;
            6'h24: alu_res = es_i_data_rs & op_b;
            6'h25: alu_res = es_i_data_rs | op_b;
            6'h26: alu_res = es_i_data_rs ^ op_b;
            6'h27: alu_res = ~(es_i_data_rs | op_b);
            6'h2A: alu_res = DWIDTH'($signed(es_i_data_rs) < $signed(op_b));
            6'h2B: alu_res = DWIDTH'(es_i_data_rs < op_b);
            6'h00: alu_res = es_i_data_rt << shamt;
            6'h02: alu_res = es_i_data_rt >> shamt;
            6'h03: alu_res = $signed(es_i_data_rt) >>> shamt;
            6'h10: alu_res = hi;
            6'h12: alu_res = lo;
            6'h18: begin is_muldiv = 1'b1; md_mult = 1'b1; md_signed = 1'b1; end
            6'h19: begin is_muldiv = 1'b1; md_mult = 1'b1; end
            6'h1A: begin is_muldiv = 1'b1; md_signed = 1'b1; end
            6'h1B: is_muldiv = 1'b1;
            default: known = 1'b0;
         endcase
         6'h08, 6'h09: alu_res = es_i_data_rs + op_b;
         6'h0C: alu_res = es_i_data_rs & op_b;
         6'h0D: alu_res = es_i_data_rs | op_b;
         6'h0E: alu_res = es_i_data_rs ^ op_b;
         6'h0A: alu_res = DWIDTH'($signed(es_i_data_rs) < $signed(op_b));
         6'h0F: alu_res = {es_i_imm, {(DWIDTH-IMM_WIDTH){1'b0}}};
         6'h23, 6'h2B: alu_res = es_i_data_rs + imm_sext;
         6'h04: taken = (es_i_data_rs == es_i_data_rt);
         6'h05: taken = (es_i_data_rs != es_i_data_rt);
         6'h03: alu_res = DWIDTH'(pc4);
         default: known = 1'b0;
      endcase
      mag_rs = (md_signed && es_i_data_rs[DWIDTH-1]) ? -es_i_data_rs : es_i_data_rs;
      mag_rt = (md_signed && es_i_data_rt[DWIDTH-1]) ? -es_i_data_rt : es_i_data_rt;
   end

   // ---------------- iterative mult/div step and sign fix ----------------
   always_comb begin
      mul_sum  = {1'b0, wk_a} + (wk_b[0] ? {1'b0, wk_m} : '0);
      div_r    = {wk_a, wk_b[DWIDTH-1]};
      div_diff = div_r - {1'b0, wk_m};
      if (state == MUL) begin
         step_a = mul_sum[DWIDTH:1];
         step_b = {mul_sum[0], wk_b[DWIDTH-1:1]};
      end else if (!div_diff[DWIDTH]) begin
         step_a = div_diff[DWIDTH-1:0];
         step_b = {wk_b[DWIDTH-2:0], 1'b1};
      end else begin
         step_a = div_r[DWIDTH-1:0];
         step_b = {wk_b[DWIDTH-2:0], 1'b0};
      end
      prod_mag = {step_a, step_b};
      prod     = neg_q ? -prod_mag : prod_mag;
      q_mag    = neg_q ? -step_b : step_b;
      // remainder follows the dividend's sign; with a zero divisor the
      // remainder magnitude is the dividend magnitude, so this restores it
      r_mag    = neg_r ? -step_a : step_a;
      if (state == MUL) begin
         fin_hi = prod[2*DWIDTH-1:DWIDTH];
         fin_lo = prod[DWIDTH-1:0];
      end else begin
         fin_hi = r_mag;
         fin_lo = div0 ? '1 : q_mag;
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge es_clk) begin
      if (!es_rst) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            state_next = IDLE;
            if (es_i_ce && is_muldiv) state_next = md_mult ? MUL : DIV;
         end
         MUL, DIV: if (last_iter) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- output / HI-LO registers ----------------
   always_ff @(posedge es_clk) begin
      if (!es_rst) begin
         es_o_ce            <= 1'b0;
         es_o_alu_result    <= '0;
         es_o_data_store    <= '0;
         es_o_rd_addr       <= '0;
         es_o_reg_wr        <= 1'b0;
         es_o_memwrite      <= 1'b0;
         es_o_memtoreg      <= 1'b0;
         es_o_jal           <= 1'b0;
         es_o_branch_taken  <= 1'b0;
         es_o_branch_target <= '0;
         es_o_jal_target    <= '0;
         hi                 <= '0;
         lo                 <= '0;
         cnt                <= '0;
      end else if (es_o_stall) begin
         wk_a <= step_a;
         wk_b <= step_b;
         cnt  <= cnt + 1'b1;
         if (last_iter) begin
            hi      <= fin_hi;
            lo      <= fin_lo;
            es_o_ce <= 1'b1;
         end
      end else if (es_i_ce && is_muldiv) begin
         wk_a              <= '0;
         wk_b              <= md_mult ? mag_rt : mag_rs;
         wk_m              <= md_mult ? mag_rs : mag_rt;
         neg_q             <= md_signed && (es_i_data_rs[DWIDTH-1] ^ es_i_data_rt[DWIDTH-1]);
         neg_r             <= md_signed && es_i_data_rs[DWIDTH-1];
         div0              <= (es_i_data_rt == '0);
         cnt               <= '0;
         es_o_ce           <= 1'b0;
         es_o_reg_wr       <= 1'b0;
         es_o_memwrite     <= 1'b0;
         es_o_jal          <= 1'b0;
         es_o_branch_taken <= 1'b0;
      end else if (es_i_ce) begin
         es_o_ce            <= 1'b1;
         es_o_alu_result    <= alu_res;
         es_o_data_store    <= es_i_data_rt;
         es_o_rd_addr       <= es_i_rd_addr;
         es_o_reg_wr        <= known && es_i_reg_wr;
         es_o_memwrite      <= known && es_i_memwrite;
         es_o_memtoreg      <= es_i_memtoreg;
         es_o_jal           <= known && es_i_jal;
         es_o_branch_taken  <= taken;
         es_o_branch_target <= pc4 + br_off;
         es_o_jal_target    <= {pc4[PC_WIDTH-1:PC_WIDTH-4], es_i_jal_addr, 2'b00};
      end else begin
         es_o_ce           <= 1'b0;
         es_o_reg_wr       <= 1'b0;
         es_o_memwrite     <= 1'b0;
         es_o_jal          <= 1'b0;
         es_o_branch_taken <= 1'b0;
      end
   end
endmodule
